// File: rtl/down_count_sequencer_pkg.sv
// Shared types and default widths for the down-count sequencer slice.
// Holds the controller state encoding and the reload counter ceiling.
package down_count_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PS_W  = 4;

    localparam logic [7:0] RELOAD_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/down_count_sequencer_if.sv
// Control/status bundle between a host and the down-count sequencer.
// The host owns the master modport; the sequencer owns the slave modport.
interface down_count_sequencer_if
    import down_count_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PS_W  = DEF_PS_W
);

    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] load_val;
    logic [PS_W-1:0]  prescale;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;
    logic [7:0]       reloads;

    modport master (
        output start, stop, pause, load_val, prescale, auto_reload,
        input  count, tc, busy, done, reloads
    );

    modport slave (
        input  start, stop, pause, load_val, prescale, auto_reload,
        output count, tc, busy, done, reloads
    );

endinterface

// File: rtl/down_count_sequencer_tick_prescaler.sv
// Free-running prescaler: emits a tick on the enabled cycle whose phase equals
// period, then wraps to phase 0. clr takes priority over en.
module tick_prescaler #(
    parameter int PS_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [PS_W-1:0] period,
    output logic            tick
);

    localparam logic [PS_W-1:0] PS_ONE = {{(PS_W-1){1'b0}}, 1'b1};

    logic [PS_W-1:0] phase_r;

    // Tick fires on the last phase of the period while enabled.
    always_comb begin
        tick = 1'b0;
        if (en && (phase_r == period)) begin
            tick = 1'b1;
        end else begin
            tick = 1'b0;
        end
    end

    // Phase counter; frozen whenever en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= {PS_W{1'b0}};
        end else if (clr) begin
            phase_r <= {PS_W{1'b0}};
        end else if (tick) begin
            phase_r <= {PS_W{1'b0}};
        end else if (en) begin
            phase_r <= phase_r + PS_ONE;
        end
    end

endmodule

// File: rtl/down_count_sequencer.sv
// Programmable down-counter with pause, one-shot/periodic modes, a registered
// terminal-count pulse and a saturating reload counter.
module down_count_sequencer
    import down_count_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PS_W  = DEF_PS_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    down_count_sequencer_if.slave bus
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] load_r;
    logic [PS_W-1:0]  period_r;
    logic             auto_r;
    logic             tc_r;
    logic             busy_r;
    logic             done_r;
    logic [7:0]       reloads_r;
    logic             ps_clr_s;
    logic             ps_en_s;
    logic             tick_s;

    // Prescaler only advances in RUN without a pause request; start/stop restart its phase.
    always_comb begin
        ps_clr_s = bus.start | bus.stop;
        if ((state_r == RUN) && !bus.pause) begin
            ps_en_s = 1'b1;
        end else begin
            ps_en_s = 1'b0;
        end
    end

    tick_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ps_clr_s),
        .en     (ps_en_s),
        .period (period_r),
        .tick   (tick_s)
    );

    // Controller: priority is stop > start > pause > tick; all status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            count_r   <= {WIDTH{1'b0}};
            load_r    <= {WIDTH{1'b0}};
            period_r  <= {PS_W{1'b0}};
            auto_r    <= 1'b0;
            tc_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            reloads_r <= 8'd0;
        end else if (bus.stop) begin
            state_r <= IDLE;
            count_r <= {WIDTH{1'b0}};
            tc_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (bus.start) begin
            load_r    <= bus.load_val;
            period_r  <= bus.prescale;
            auto_r    <= bus.auto_reload;
            count_r   <= bus.load_val;
            reloads_r <= 8'd0;
            tc_r      <= 1'b0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            state_r   <= bus.pause ? PAUSED : RUN;
        end else begin
            case (state_r)
                RUN: begin
                    tc_r <= 1'b0;
                    if (bus.pause) begin
                        state_r <= PAUSED;
                    end else if (tick_s) begin
                        if (count_r != {WIDTH{1'b0}}) begin
                            count_r <= count_r - CNT_ONE;
                        end else begin
                            tc_r <= 1'b1;
                            if (auto_r) begin
                                count_r <= load_r;
                                if (reloads_r != RELOAD_MAX) begin
                                    reloads_r <= reloads_r + 8'd1;
                                end
                            end else begin
                                state_r <= DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end
                        end
                    end
                end
                PAUSED: begin
                    tc_r <= 1'b0;
                    if (!bus.pause) begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    tc_r <= 1'b0;
                end
                IDLE: begin
                    tc_r <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= {WIDTH{1'b0}};
                    tc_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count   = count_r;
    assign bus.tc      = tc_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.reloads = reloads_r;

endmodule
